exmem_stage: RTL and testbench

- Execute stage plus EX/MEM pipeline register. Sits directly downstream of the ID/EX register and consumes its registered outputs (control groups, operands, immediate, register IDs).
- Performs single-cycle ALU ops and 16-iteration multi-cycle unsigned multiply/divide.
- Stalls upstream while mul/div runs, and presents registered results to the MEM stage.

---
 rtl/exmem_stage.sv | 181 ++++++++++++++++++
 tb/tb_exmem_stage.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/exmem_stage.sv
`timescale 1ns/1ps
// Execute stage + EX/MEM register: single-cycle ALU ops, 16-step unsigned mul/div; EXMEM_FORWARD_EN adds EX/MEM->EX forwarding.
// Latency: ALU 1 edge; mul/div result lands 17 edges after issue.
// Backpressure: stall holds ID/EX from issue until the final mul/div step; flush and reset drop it.
module exmem_stage #(
    parameter int DATA_W = 16,
    parameter int REG_W  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic [1:0]        WBreg,
    input  logic [2:0]        Mreg,
    input  logic [3:0]        EXreg,
    input  logic [DATA_W-1:0] op1reg,
    input  logic [DATA_W-1:0] op2reg,
    input  logic [DATA_W-1:0] imm_valuereg,
    input  logic [REG_W-1:0]  readReg1reg,
    input  logic [REG_W-1:0]  readReg2reg,
    output logic              stall,
    output logic [1:0]        WB_out,
    output logic [2:0]        M_out,
    output logic [DATA_W-1:0] alu_result,
    output logic [DATA_W-1:0] hi_result,
    output logic              hi_write,
    output logic [DATA_W-1:0] store_data,
    output logic [REG_W-1:0]  dest_reg,
    output logic              zero_flag,
    output logic              ovf_flag
);
    localparam int CNT_W = $clog2(DATA_W);

    typedef enum logic {S_IDLE = 1'b0, S_BUSY = 1'b1} state_t;

    state_t            r_state, w_state_nxt;
    logic [CNT_W-1:0]  r_cnt;
    logic [DATA_W-1:0] r_md_hi, r_md_lo, r_md_b;
    logic              r_md_div;
    logic [1:0]        r_md_wb;
    logic [2:0]        r_md_m;
    logic [REG_W-1:0]  r_md_dest;

    logic [1:0]        r_wb;
    logic [2:0]        r_m;
    logic [DATA_W-1:0] r_alu, r_hi, r_store;
    logic              r_hiw, r_zero, r_ovf;
    logic [REG_W-1:0]  r_dest;

    logic [DATA_W-1:0] w_op_a, w_op_b_reg, w_op_b, w_sum, w_diff, w_alu;
    logic [DATA_W-1:0] w_mul_hi, w_mul_lo, w_div_hi, w_div_lo, w_step_hi, w_step_lo;
    logic [DATA_W:0]   w_mul_sum, w_div_trial;
    logic [2:0]        w_func;
    logic              w_is_md, w_last, w_ovf, w_div_ok;

`ifdef EXMEM_FORWARD_EN
    logic w_fwd_a, w_fwd_b;
    assign w_fwd_a    = (r_state == S_IDLE) && r_wb[1] && (r_dest == readReg1reg);
    assign w_fwd_b    = (r_state == S_IDLE) && r_wb[1] && (r_dest == readReg2reg);
    assign w_op_a     = w_fwd_a ? r_alu : op1reg;
    assign w_op_b_reg = w_fwd_b ? r_alu : op2reg;
`else
    logic w_unused_src2;
    assign w_unused_src2 = ^readReg2reg;
    assign w_op_a        = op1reg;
    assign w_op_b_reg    = op2reg;
`endif

    assign w_op_b  = EXreg[3] ? imm_valuereg : w_op_b_reg;
    assign w_func  = EXreg[2:0];
    assign w_is_md = (w_func[2:1] == 2'b10);
    assign w_last  = (r_state == S_BUSY) && (r_cnt == CNT_W'(DATA_W - 1));
    assign w_sum   = w_op_a + w_op_b;
    assign w_diff  = w_op_a - w_op_b;

    always_comb begin
        w_alu = '0;
        w_ovf = 1'b0;
        case (w_func)
            3'b000: begin
                w_alu = w_sum;
                w_ovf = (w_op_a[DATA_W-1] == w_op_b[DATA_W-1]) && (w_sum[DATA_W-1] != w_op_a[DATA_W-1]);
            end
            3'b001: begin
                w_alu = w_diff;
                w_ovf = (w_op_a[DATA_W-1] != w_op_b[DATA_W-1]) && (w_diff[DATA_W-1] != w_op_a[DATA_W-1]);
            end
            3'b010:  w_alu = w_op_a & w_op_b;
            3'b011:  w_alu = w_op_a | w_op_b;
            3'b110:  w_alu = w_op_a << w_op_b[CNT_W-1:0];
            3'b111:  w_alu = w_op_a >> w_op_b[CNT_W-1:0];
            default: w_alu = '0;
        endcase
    end

    // Shift-add keeps {hi,lo} as {partial product, remaining multiplier};
    // restoring divide keeps {remainder, dividend/quotient}. A zero divisor
    // always "fits", which yields all-ones quotient and remainder = A.
    assign w_mul_sum   = {1'b0, r_md_hi} + {1'b0, (r_md_lo[0] ? r_md_b : {DATA_W{1'b0}})};
    assign w_mul_hi    = w_mul_sum[DATA_W:1];
    assign w_mul_lo    = {w_mul_sum[0], r_md_lo[DATA_W-1:1]};
    assign w_div_trial = {r_md_hi, r_md_lo[DATA_W-1]} - {1'b0, r_md_b};
    assign w_div_ok    = ~w_div_trial[DATA_W];
    assign w_div_hi    = w_div_ok ? w_div_trial[DATA_W-1:0] : {r_md_hi[DATA_W-2:0], r_md_lo[DATA_W-1]};
    assign w_div_lo    = {r_md_lo[DATA_W-2:0], w_div_ok};
    assign w_step_hi   = r_md_div ? w_div_hi : w_mul_hi;
    assign w_step_lo   = r_md_div ? w_div_lo : w_mul_lo;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (!flush && w_is_md)  w_state_nxt = S_BUSY;
            S_BUSY:  if (flush || w_last)    w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        stall = 1'b0;
        if (!reset && !flush)
            stall = (r_state == S_IDLE) ? w_is_md : !w_last;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt     <= '0;
            r_md_hi   <= '0;
            r_md_lo   <= '0;
            r_md_b    <= '0;
            r_md_div  <= 1'b0;
            r_md_wb   <= '0;
            r_md_m    <= '0;
            r_md_dest <= '0;
        end else if (flush) begin
            r_cnt <= '0;
        end else if (r_state == S_IDLE && w_is_md) begin
            r_cnt     <= '0;
            r_md_hi   <= '0;
            r_md_lo   <= w_op_a;
            r_md_b    <= w_op_b;
            r_md_div  <= w_func[0];
            r_md_wb   <= WBreg;
            r_md_m    <= Mreg;
            r_md_dest <= readReg1reg;
        end else if (r_state == S_BUSY) begin
            r_cnt   <= r_cnt + CNT_W'(1);
            r_md_hi <= w_step_hi;
            r_md_lo <= w_step_lo;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wb <= '0; r_m <= '0; r_alu <= '0; r_hi <= '0; r_hiw <= 1'b0;
            r_store <= '0; r_dest <= '0; r_zero <= 1'b0; r_ovf <= 1'b0;
        end else if (w_last && !flush) begin
            r_wb <= r_md_wb; r_m <= r_md_m; r_alu <= w_step_lo; r_hi <= w_step_hi; r_hiw <= 1'b1;
            r_store <= '0; r_dest <= r_md_dest; r_zero <= (w_step_lo == '0); r_ovf <= 1'b0;
        end else if (flush || r_state == S_BUSY || w_is_md) begin
            r_wb <= '0; r_m <= '0; r_alu <= '0; r_hi <= '0; r_hiw <= 1'b0;
            r_store <= '0; r_dest <= '0; r_zero <= 1'b0; r_ovf <= 1'b0;
        end else begin
            r_wb <= WBreg; r_m <= Mreg; r_alu <= w_alu; r_hi <= '0; r_hiw <= 1'b0;
            r_store <= w_op_b_reg; r_dest <= readReg1reg; r_zero <= (w_alu == '0); r_ovf <= w_ovf;
        end
    end

    assign WB_out     = r_wb;
    assign M_out      = r_m;
    assign alu_result = r_alu;
    assign hi_result  = r_hi;
    assign hi_write   = r_hiw;
    assign store_data = r_store;
    assign dest_reg   = r_dest;
    assign zero_flag  = r_zero;
    assign ovf_flag   = r_ovf;
endmodule

// File: tb/tb_exmem_stage.sv
`timescale 1ns/1ps
// Bench for exmem_stage: directed literal checks plus randomized traffic against a transaction-level model.
module tb_exmem_stage;
    logic        clk = 1'b0, reset = 1'b1, flush = 1'b0;
    logic [1:0]  WBreg = '0;
    logic [2:0]  Mreg = '0;
    logic [3:0]  EXreg = '0;
    logic [15:0] op1reg = '0, op2reg = '0, imm_valuereg = '0;
    logic [3:0]  readReg1reg = '0, readReg2reg = '0;
    logic        stall, hi_write, zero_flag, ovf_flag;
    logic [1:0]  WB_out;
    logic [2:0]  M_out;
    logic [15:0] alu_result, hi_result, store_data;
    logic [3:0]  dest_reg;

    exmem_stage #(.DATA_W(16), .REG_W(4)) dut (
        .clk(clk), .reset(reset), .flush(flush), .WBreg(WBreg), .Mreg(Mreg), .EXreg(EXreg),
        .op1reg(op1reg), .op2reg(op2reg), .imm_valuereg(imm_valuereg),
        .readReg1reg(readReg1reg), .readReg2reg(readReg2reg), .stall(stall),
        .WB_out(WB_out), .M_out(M_out), .alu_result(alu_result), .hi_result(hi_result),
        .hi_write(hi_write), .store_data(store_data), .dest_reg(dest_reg),
        .zero_flag(zero_flag), .ovf_flag(ovf_flag));

    always #5 clk = ~clk;

    int n_cmp = 0, n_err = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Expected EX/MEM contents plus an in-flight mul/div as a precomputed answer with a countdown.
    logic [1:0]  e_wb = '0;
    logic [2:0]  e_m = '0;
    logic [15:0] e_alu = '0, e_hi = '0, e_store = '0;
    logic        e_hiw = 1'b0, e_zero = 1'b0, e_ovf = 1'b0;
    logic [3:0]  e_dest = '0;
    bit          e_bubble = 1'b1, e_store_vld = 1'b1;
    bit          m_busy = 1'b0;
    int          m_left = 0;
    logic [15:0] m_lo = '0, m_hi = '0;
    logic [1:0]  m_wb = '0;
    logic [2:0]  m_m = '0;
    logic [3:0]  m_dest = '0;

    function automatic bit is_md(input logic [3:0] ex);
        return ex[2:1] == 2'b10;
    endfunction

    function automatic bit exp_stall();
        if (reset || flush) return 1'b0;
        return m_busy ? (m_left != 1) : is_md(EXreg);
    endfunction

    task automatic bubble();
        e_wb = '0; e_m = '0; e_alu = '0; e_hi = '0; e_hiw = 1'b0; e_store = '0;
        e_dest = '0; e_zero = 1'b0; e_ovf = 1'b0; e_bubble = 1'b1; e_store_vld = 1'b1;
    endtask

    task automatic model_step();
        logic [15:0] a, br, b, r;
        logic        ov;
        a  = op1reg;
        br = op2reg;
`ifdef EXMEM_FORWARD_EN
        if (!m_busy && e_wb[1] && e_dest == readReg1reg) a  = e_alu;
        if (!m_busy && e_wb[1] && e_dest == readReg2reg) br = e_alu;
`endif
        b = EXreg[3] ? imm_valuereg : br;
        if (flush) begin
            bubble();
            m_busy = 1'b0;
        end else if (m_busy) begin
            m_left--;
            if (m_left == 0) begin
                m_busy = 1'b0;
                e_wb = m_wb; e_m = m_m; e_alu = m_lo; e_hi = m_hi; e_hiw = 1'b1;
                e_dest = m_dest; e_zero = (m_lo == 16'h0); e_ovf = 1'b0;
                e_bubble = 1'b0; e_store_vld = 1'b0;
            end else bubble();
        end else if (is_md(EXreg)) begin
            m_busy = 1'b1; m_left = 16; m_wb = WBreg; m_m = Mreg; m_dest = readReg1reg;
            if (!EXreg[0])      {m_hi, m_lo} = {16'h0, a} * {16'h0, b};
            else if (b == 16'h0) begin m_lo = 16'hFFFF; m_hi = a; end
            else begin m_lo = a / b; m_hi = a % b; end
            bubble();
        end else begin
            ov = 1'b0;
            case (EXreg[2:0])
                3'b000: begin r = a + b; ov = (a[15] == b[15]) && (r[15] != a[15]); end
                3'b001: begin r = a - b; ov = (a[15] != b[15]) && (r[15] != a[15]); end
                3'b010: r = a & b;
                3'b011: r = a | b;
                3'b110: r = a << b[3:0];
                default: r = a >> b[3:0];
            endcase
            e_wb = WBreg; e_m = Mreg; e_alu = r; e_hi = '0; e_hiw = 1'b0; e_store = br;
            e_dest = readReg1reg; e_zero = (r == 16'h0); e_ovf = ov; e_bubble = 1'b0; e_store_vld = 1'b1;
        end
    endtask

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            bubble();
            m_busy = 1'b0;
            m_left = 0;
        end else model_step();
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("stall", 32'(stall), 32'(exp_stall()));
            chk("WB_out", 32'(WB_out), 32'(e_wb));
            chk("M_out", 32'(M_out), 32'(e_m));
            chk("alu_result", 32'(alu_result), 32'(e_alu));
            chk("hi_result", 32'(hi_result), 32'(e_hi));
            chk("hi_write", 32'(hi_write), 32'(e_hiw));
            chk("dest_reg", 32'(dest_reg), 32'(e_dest));
            chk("ovf_flag", 32'(ovf_flag), 32'(e_ovf));
            if (!e_bubble)   chk("zero_flag", 32'(zero_flag), 32'(e_zero));
            if (e_store_vld) chk("store_data", 32'(store_data), 32'(e_store));
        end
    end

    task automatic set_in(input logic [1:0] wb, input logic [2:0] m, input logic [3:0] ex,
                          input logic [15:0] a, input logic [15:0] b, input logic [15:0] imm,
                          input logic [3:0] r1, input logic [3:0] r2);
        WBreg = wb; Mreg = m; EXreg = ex; op1reg = a; op2reg = b; imm_valuereg = imm;
        readReg1reg = r1; readReg2reg = r2;
    endtask

    // Holds the presented instruction until stall drops, like ID/EX would; returns edges taken.
    task automatic run_instr(output int edges);
        bit st;
        edges = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            st = stall;
            @(posedge clk);
            #2;
            edges++;
            if (!st) return;
        end
        n_cmp++;
        n_err++;
        $display("FAIL stall_timeout: stall still 1 after %0d edges, required release by 17", edges);
    endtask

    function automatic logic [15:0] rval();
        case ($urandom_range(0, 4))
            0: return 16'h0000;
            1: return 16'h7FFF;
            2: return 16'h8000;
            3: return 16'($urandom_range(0, 20));
            default: return 16'($urandom);
        endcase
    endfunction

    initial begin
        int ed;
        bit st;
        set_in(2'b10, 3'b000, 4'b0100, 16'h1234, 16'h0010, 16'h0, 4'd1, 4'd2);
        repeat (2) @(posedge clk);
        #2;
        chk_en = 1'b1;
        #1;
        chk("reset_stall", 32'(stall), 32'h0);
        chk("reset_WB", 32'(WB_out), 32'h0);
        chk("reset_alu", 32'(alu_result), 32'h0);
        chk("reset_hiw", 32'(hi_write), 32'h0);
        reset = 1'b0;

        set_in(2'b10, 3'b000, 4'b0000, 16'h0003, 16'h0004, 16'h0, 4'd1, 4'd2);
        run_instr(ed);
        chk("add_edges", 32'(ed), 32'd1);
        chk("add_alu", 32'(alu_result), 32'h0007);
        chk("add_zero", 32'(zero_flag), 32'h0);
        chk("add_ovf", 32'(ovf_flag), 32'h0);
        chk("add_WB", 32'(WB_out), 32'h2);

        set_in(2'b10, 3'b000, 4'b0000, 16'h7FFF, 16'h0001, 16'h0, 4'd1, 4'd2);
        run_instr(ed);
        chk("addovf_alu", 32'(alu_result), 32'h8000);
        chk("addovf_ovf", 32'(ovf_flag), 32'h1);

        set_in(2'b10, 3'b000, 4'b0001, 16'h8000, 16'h0001, 16'h0, 4'd1, 4'd2);
        run_instr(ed);
        chk("subovf_alu", 32'(alu_result), 32'h7FFF);
        chk("subovf_ovf", 32'(ovf_flag), 32'h1);

        set_in(2'b10, 3'b010, 4'b0100, 16'h1234, 16'h0010, 16'h0, 4'd5, 4'd6);
        run_instr(ed);
        chk("mul_edges", 32'(ed), 32'd17);
        chk("mul_lo", 32'(alu_result), 32'h2340);
        chk("mul_hi", 32'(hi_result), 32'h0001);
        chk("mul_hiw", 32'(hi_write), 32'h1);
        chk("mul_WB", 32'(WB_out), 32'h2);

        set_in(2'b10, 3'b000, 4'b1011, 16'h00F0, 16'hFFFF, 16'h000F, 4'd7, 4'd6);
        run_instr(ed);
        chk("or_imm_alu", 32'(alu_result), 32'h00FF);
        chk("or_imm_hiw", 32'(hi_write), 32'h0);
        chk("or_imm_store", 32'(store_data), 32'hFFFF);

        set_in(2'b10, 3'b000, 4'b0101, 16'h0064, 16'h0007, 16'h0, 4'd5, 4'd6);
        run_instr(ed);
        chk("div_edges", 32'(ed), 32'd17);
        chk("div_q", 32'(alu_result), 32'h000E);
        chk("div_r", 32'(hi_result), 32'h0002);

        set_in(2'b10, 3'b000, 4'b0101, 16'h1234, 16'h0000, 16'h0, 4'd5, 4'd6);
        run_instr(ed);
        chk("div0_q", 32'(alu_result), 32'hFFFF);
        chk("div0_r", 32'(hi_result), 32'h1234);

        // Flush while the counter reads 5 (six edges after the multiply is presented).
        set_in(2'b10, 3'b101, 4'b0100, 16'h1234, 16'h0010, 16'h0, 4'd5, 4'd6);
        repeat (6) @(posedge clk);
        #2;
        chk("preflush_stall", 32'(stall), 32'h1);
        flush = 1'b1;
        @(negedge clk);
        chk("flush_stall", 32'(stall), 32'h0);
        @(posedge clk);
        #2;
        flush = 1'b0;
        chk("flush_WB", 32'(WB_out), 32'h0);
        chk("flush_M", 32'(M_out), 32'h0);
        chk("flush_hiw", 32'(hi_write), 32'h0);
        set_in(2'b10, 3'b000, 4'b0000, 16'h0001, 16'h0001, 16'h0, 4'd2, 4'd6);
        run_instr(ed);
        chk("postflush_edges", 32'(ed), 32'd1);
        chk("postflush_alu", 32'(alu_result), 32'h0002);

        // Reset while the divide counter reads 8 (nine edges after presentation).
        set_in(2'b10, 3'b000, 4'b0101, 16'h0064, 16'h0007, 16'h0, 4'd5, 4'd6);
        repeat (9) @(posedge clk);
        #2;
        chk("prereset_stall", 32'(stall), 32'h1);
        reset = 1'b1;
        #1;
        chk("midreset_stall", 32'(stall), 32'h0);
        chk("midreset_WB", 32'(WB_out), 32'h0);
        chk("midreset_hi", 32'(hi_result), 32'h0);
        @(posedge clk);
        #2;
        reset = 1'b0;
        set_in(2'b10, 3'b000, 4'b0101, 16'h0009, 16'h0003, 16'h0, 4'd5, 4'd6);
        run_instr(ed);
        chk("postreset_edges", 32'(ed), 32'd17);
        chk("postreset_q", 32'(alu_result), 32'h0003);
        chk("postreset_r", 32'(hi_result), 32'h0000);

        set_in(2'b10, 3'b000, 4'b0000, 16'h0002, 16'h0003, 16'h0, 4'd3, 4'd1);
        run_instr(ed);
        chk("fwd_src_alu", 32'(alu_result), 32'h0005);
        set_in(2'b10, 3'b000, 4'b0000, 16'h0000, 16'h0000, 16'h0, 4'd3, 4'd3);
        run_instr(ed);
`ifdef EXMEM_FORWARD_EN
        chk("fwd_alu", 32'(alu_result), 32'h000A);
`else
        chk("fwd_alu", 32'(alu_result), 32'h0000);
`endif

        st = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if (!st)
                set_in(2'($urandom), 3'($urandom), 4'($urandom), rval(), rval(), rval(),
                       4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)));
            flush = ($urandom_range(0, 24) == 0);
            @(negedge clk);
            st = stall;
            @(posedge clk);
            #2;
        end
        flush = 1'b0;
        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit, required to reach summary");
        $fatal(1, "watchdog expired");
    end
endmodule
